// File: rtl/wsi_req_pkg.sv
// Shared definitions for the WSI request arbiter: request word field map,
// idle command code and arbiter state encoding.
package wsi_req_pkg;

  localparam int unsigned WSI_REQ_W = 61;

  localparam int unsigned CMD_HI   = 60;
  localparam int unsigned CMD_LO   = 58;
  localparam int unsigned LAST_BIT = 57;
  localparam int unsigned PREC_BIT = 56;
  localparam int unsigned LEN_HI   = 55;
  localparam int unsigned LEN_LO   = 44;

  localparam logic [2:0] CMD_IDLE = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wsi_burst_checker.sv
// Burst beat counter and, with WSI_ARB_BURST_CHECK_EN defined, the precise-burst
// length checker driving the sticky err_len flag.
module wsi_burst_checker
  import wsi_req_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic        first,
`ifdef WSI_ARB_BURST_CHECK_EN
  input  logic        last,
  input  logic        prec_in,
  input  logic [11:0] len_in,
  input  logic        err_clr,
`endif
  output logic        err_len
);

  logic [11:0] beat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (first) begin
      beat_cnt <= 12'd1;
    end else if (accept && beat_cnt != '1) begin
      beat_cnt <= beat_cnt + 12'd1;
    end
  end

`ifdef WSI_ARB_BURST_CHECK_EN
  logic [11:0] len_q;
  logic        prec_q;
  logic        chk_prec;
  logic [11:0] chk_len;
  logic [12:0] total;
  logic        err_set;

  // A single-beat burst is checked against its own fields, not the latched ones.
  always_comb begin
    chk_prec = first ? prec_in : prec_q;
    chk_len  = first ? len_in : len_q;
    total    = first ? 13'd1 : ({1'b0, beat_cnt} + 13'd1);
    err_set  = accept && last && chk_prec &&
               ((total != {1'b0, chk_len}) || (chk_len == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      prec_q  <= 1'b0;
      err_len <= 1'b0;
    end else begin
      if (first && !last) begin
        len_q  <= len_in;
        prec_q <= prec_in;
      end
      if (err_set) begin
        err_len <= 1'b1;
      end else if (err_clr) begin
        err_len <= 1'b0;
      end
    end
  end
`else
  assign err_len = 1'b0;
`endif

endmodule

// File: rtl/wsi_req_arbiter.sv
// Burst-aware round-robin arbiter sharing the WSI request FIFO write port
// between two sources. Length checking is built when WSI_ARB_BURST_CHECK_EN is defined.
module wsi_req_arbiter
  import wsi_req_pkg::*;
#(
  parameter int unsigned PRIO_INIT = 0,
  parameter int unsigned DW        = WSI_REQ_W
) (
  input  logic          wciS0_Clk,
  input  logic          wciS0_Rst,
  input  logic          src0_valid,
  input  logic [DW-1:0] src0_data,
  output logic          src0_ready,
  input  logic          src1_valid,
  input  logic [DW-1:0] src1_data,
  output logic          src1_ready,
  input  logic          fifo_full,
  output logic          fifo_we,
  output logic [DW-1:0] fifo_din,
  output logic [1:0]    grant,
  output logic          locked,
  output logic          err_len,
  input  logic          err_clr
);

  arb_state_t    state;
  logic          rr_ptr;
  logic          beat0;
  logic          beat1;
  logic          sel_vld;
  logic          sel1;
  logic          open;
  logic          accept;
  logic          acc_first;
  logic          acc_last;
  logic [DW-1:0] sel_data;

  assign beat0 = src0_valid && (src0_data[CMD_HI:CMD_LO] != CMD_IDLE);
  assign beat1 = src1_valid && (src1_data[CMD_HI:CMD_LO] != CMD_IDLE);

  // While locked the owner stays selected even without a valid beat, which
  // keeps the other source's ready low for the whole burst.
  always_comb begin
    sel_vld = 1'b0;
    sel1    = 1'b0;
    case (state)
      IDLE: begin
        sel_vld = beat0 || beat1;
        sel1    = beat1 && (!beat0 || rr_ptr);
      end
      LOCK0: begin
        sel_vld = 1'b1;
        sel1    = 1'b0;
      end
      LOCK1: begin
        sel_vld = 1'b1;
        sel1    = 1'b1;
      end
      default: begin
        sel_vld = 1'b0;
        sel1    = 1'b0;
      end
    endcase
  end

  assign open       = !wciS0_Rst && !fifo_full && sel_vld;
  assign src0_ready = open && !sel1;
  assign src1_ready = open && sel1;
  assign accept     = (src0_ready && beat0) || (src1_ready && beat1);
  assign sel_data   = sel1 ? src1_data : src0_data;
  assign acc_first  = accept && (state == IDLE);
  assign acc_last   = accept && sel_data[LAST_BIT];

  assign fifo_we  = accept;
  assign fifo_din = sel_data;
  assign grant    = (wciS0_Rst || !sel_vld) ? 2'b00 : (sel1 ? 2'b10 : 2'b01);
  assign locked   = (state != IDLE);

  always_ff @(posedge wciS0_Clk or posedge wciS0_Rst) begin
    if (wciS0_Rst) begin
      state  <= IDLE;
      rr_ptr <= PRIO_INIT[0];
    end else if (accept) begin
      if (state == IDLE) begin
        if (acc_last) begin
          rr_ptr <= !sel1;
        end else begin
          state <= sel1 ? LOCK1 : LOCK0;
        end
      end else if (acc_last) begin
        state  <= IDLE;
        rr_ptr <= !sel1;
      end
    end
  end

  wsi_burst_checker u_chk (
    .clk     (wciS0_Clk),
    .rst     (wciS0_Rst),
    .accept  (accept),
    .first   (acc_first),
`ifdef WSI_ARB_BURST_CHECK_EN
    .last    (acc_last),
    .prec_in (sel_data[PREC_BIT]),
    .len_in  (sel_data[LEN_HI:LEN_LO]),
    .err_clr (err_clr),
`endif
    .err_len (err_len)
  );

`ifndef WSI_ARB_BURST_CHECK_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_wsi_req_arbiter.sv
// Self-checking bench for wsi_req_arbiter against a transaction-level model.
module tb_wsi_req_arbiter;

  logic        clk = 1'b0;
  logic        rst, s0v, s1v, full, clr;
  logic [60:0] s0d, s1d;
  logic        s0r, s1r, fifo_we, locked, err_len;
  logic [60:0] fifo_din;
  logic [1:0]  grant;

  int total = 0;
  int bad   = 0;

`ifdef WSI_ARB_BURST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  wsi_req_arbiter #(.PRIO_INIT(0)) dut (
    .wciS0_Clk (clk),     .wciS0_Rst (rst),
    .src0_valid(s0v),     .src0_data(s0d), .src0_ready(s0r),
    .src1_valid(s1v),     .src1_data(s1d), .src1_ready(s1r),
    .fifo_full (full),    .fifo_we  (fifo_we), .fifo_din(fifo_din),
    .grant     (grant),   .locked   (locked),
    .err_len   (err_len), .err_clr  (clr)
  );

  // Model: owner of the open burst (-1 none), preferred source, beats seen.
  int m_owner, m_rr, m_cnt, m_len;
  bit m_prec, m_err;

  typedef struct {
    bit          we, r0, r1, lck, err;
    bit [1:0]    gnt;
    logic [60:0] din;
    int          sel;
  } exp_t;

  function automatic void model_reset();
    m_owner = -1; m_rr = 0; m_cnt = 0; m_len = 0; m_prec = 0; m_err = 0;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    bit v0, v1;
    e.we = 0; e.r0 = 0; e.r1 = 0; e.gnt = 0; e.din = '0;
    v0 = s0v && (s0d[60:58] != 3'd0);
    v1 = s1v && (s1d[60:58] != 3'd0);
    if (m_owner >= 0)  e.sel = m_owner;
    else if (v0 && v1) e.sel = m_rr;
    else if (v0)       e.sel = 0;
    else if (v1)       e.sel = 1;
    else               e.sel = -1;
    if (!rst && e.sel >= 0) begin
      e.gnt = (e.sel == 1) ? 2'b10 : 2'b01;
      e.r0  = (e.sel == 0) && !full;
      e.r1  = (e.sel == 1) && !full;
      e.we  = (e.sel == 0) ? (e.r0 && v0) : (e.r1 && v1);
      e.din = (e.sel == 1) ? s1d : s0d;
    end
    e.lck = (m_owner >= 0);
    e.err = m_err;
    return e;
  endfunction

  function automatic void model_commit(exp_t e);
    bit set, done;
    int n, plen;
    bit pp;
    set = 0; done = 0; n = 0; plen = 0; pp = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (e.we) begin
      if (m_owner < 0) begin
        if (e.din[57]) begin
          done = 1; n = 1; plen = int'(e.din[55:44]); pp = e.din[56];
        end else begin
          m_owner = e.sel; m_cnt = 1; m_len = int'(e.din[55:44]); m_prec = e.din[56];
        end
      end else begin
        m_cnt = (m_cnt < 4095) ? m_cnt + 1 : 4095;
        if (e.din[57]) begin
          done = 1; n = m_cnt; plen = m_len; pp = m_prec;
        end
      end
      if (done) begin
        if (CHK && pp && (n != plen || plen == 0)) set = 1;
        m_owner = -1;
        m_rr    = 1 - e.sel;
      end
    end
    if (set) m_err = 1;
    else if (CHK && clr) m_err = 0;
  endfunction

  function automatic logic [60:0] mk(logic [2:0] cmd, bit last, bit prec, logic [11:0] len);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {cmd, last, prec, len, r[43:0]};
  endfunction

  task automatic advance(input exp_t e);
    @(posedge clk);
    model_commit(e);
    #1;
  endtask

  task automatic idle_inputs();
    s0v = 0; s1v = 0; s0d = '0; s1d = '0; full = 0; clr = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1; idle_inputs(); model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #2 e = model_eval();
    total++;
    if ({fifo_we, s0r, s1r, grant, locked, err_len} !== 7'b0) begin
      bad++; $display("FAIL reset_state got=%b exp=%b", {fifo_we, s0r, s1r, grant, locked, err_len}, 7'b0);
    end
    s1v = 1; s1d = mk(3'd1, 0, 1, 12'd4);
    for (int i = 0; i < 2; i++) begin
      #2 e = model_eval();
      total++;
      if ({fifo_we, s0r, s1r, grant, locked, err_len} !== {e.we, e.r0, e.r1, e.gnt, e.lck, e.err}) begin
        bad++; $display("FAIL reset_burst cyc=%0d got=%b exp=%b", i, {fifo_we, s0r, s1r, grant, locked, err_len}, {e.we, e.r0, e.r1, e.gnt, e.lck, e.err});
      end
      advance(e);
      s1d = mk(3'd1, 0, 1, 12'd4);
    end
    rst = 1; model_reset();
    #1;
    total++;
    if (s1r !== 1'b0 || fifo_we !== 1'b0) begin
      bad++; $display("FAIL reset_midlock_outputs got=%b%b exp=00", s1r, fifo_we);
    end
    @(posedge clk); #1 rst = 0; s1v = 0;
    #2;
    total++;
    if (grant !== 2'b00 || locked !== 1'b0) begin
      bad++; $display("FAIL reset_release got=%b%b exp=000", grant, locked);
    end
    s0v = 1; s0d = mk(3'd1, 1, 0, 12'd1);
    s1v = 1; s1d = mk(3'd2, 1, 0, 12'd1);
    #1 e = model_eval();
    total++;
    if (fifo_we !== 1'b1 || fifo_din !== s0d) begin
      bad++; $display("FAIL reset_prio got=%b/%h exp=1/%h", fifo_we, fifo_din, s0d);
    end
    advance(e);
    idle_inputs();
  endtask

  task automatic test_contention();
    exp_t e;
    int src;
    src = m_rr;
    for (int i = 0; i < 8; i++) begin
      s0v = 1; s0d = mk(3'($urandom_range(1, 7)), 1, 0, 12'd1);
      s1v = 1; s1d = mk(3'($urandom_range(1, 7)), 1, 0, 12'd1);
      #2 e = model_eval();
      total++;
      if ({fifo_we, s0r, s1r, grant, locked, err_len} !== {e.we, e.r0, e.r1, e.gnt, e.lck, e.err}) begin
        bad++; $display("FAIL contention_ctl cyc=%0d got=%b exp=%b", i, {fifo_we, s0r, s1r, grant, locked, err_len}, {e.we, e.r0, e.r1, e.gnt, e.lck, e.err});
      end
      total++;
      if (fifo_we !== 1'b1 || fifo_din !== (src == 1 ? s1d : s0d)) begin
        bad++; $display("FAIL contention_alt cyc=%0d got=%h exp=%h", i, fifo_din, (src == 1 ? s1d : s0d));
      end
      src = 1 - src;
      advance(e);
    end
    idle_inputs();
  endtask

  task automatic test_burst_lock();
    exp_t e;
    if (m_rr == 1) begin
      s1v = 1; s1d = mk(3'd1, 1, 0, 12'd1);
      #2 e = model_eval(); advance(e);
    end
    for (int i = 0; i < 5; i++) begin
      s0v = (i < 4); s0d = mk(3'd1, i == 3, 1, 12'd4);
      s1v = 1;       s1d = mk(3'd3, 1, 0, 12'd1);
      #2 e = model_eval();
      total++;
      if ({fifo_we, s0r, s1r, grant, locked, err_len} !== {e.we, e.r0, e.r1, e.gnt, e.lck, e.err}) begin
        bad++; $display("FAIL lock_ctl cyc=%0d got=%b exp=%b", i, {fifo_we, s0r, s1r, grant, locked, err_len}, {e.we, e.r0, e.r1, e.gnt, e.lck, e.err});
      end
      total++;
      if ((i < 4 && (s1r !== 1'b0 || locked !== (i > 0) || fifo_din !== s0d)) ||
          (i == 4 && (grant !== 2'b10 || locked !== 1'b0))) begin
        bad++; $display("FAIL lock_rule cyc=%0d got=r1:%b lck:%b gnt:%b", i, s1r, locked, grant);
      end
      advance(e);
    end
    total++;
    if (err_len !== 1'b0) begin
      bad++; $display("FAIL lock_err got=%b exp=0", err_len);
    end
    idle_inputs();
  endtask

  task automatic test_len_error();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      s1v = (i < 2); s1d = mk(3'd2, i == 1, 1, 12'd3);
      clr = (i == 3);
      #2 e = model_eval();
      total++;
      if ({fifo_we, s0r, s1r, grant, locked, err_len} !== {e.we, e.r0, e.r1, e.gnt, e.lck, e.err}) begin
        bad++; $display("FAIL lenerr_ctl cyc=%0d got=%b exp=%b", i, {fifo_we, s0r, s1r, grant, locked, err_len}, {e.we, e.r0, e.r1, e.gnt, e.lck, e.err});
      end
      if (i == 2) begin
        total++;
        if (err_len !== CHK) begin
          bad++; $display("FAIL lenerr_set got=%b exp=%b", err_len, CHK);
        end
      end
      advance(e);
    end
    total++;
    if (err_len !== 1'b0) begin
      bad++; $display("FAIL lenerr_clr got=%b exp=0", err_len);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [60:0] beats[6];
    logic [60:0] seen[$];
    int idx, cyc;
    for (int i = 0; i < 6; i++) beats[i] = mk(3'd1, i == 5, 1, 12'd6);
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 30) begin
      s0v = 1; s0d = beats[idx];
      full = (cyc >= 2 && cyc < 7);
      #2 e = model_eval();
      total++;
      if ({fifo_we, s0r, s1r, grant, locked, err_len} !== {e.we, e.r0, e.r1, e.gnt, e.lck, e.err}) begin
        bad++; $display("FAIL bp_ctl cyc=%0d got=%b exp=%b", cyc, {fifo_we, s0r, s1r, grant, locked, err_len}, {e.we, e.r0, e.r1, e.gnt, e.lck, e.err});
      end
      if (fifo_we === 1'b1) seen.push_back(fifo_din);
      if (e.we) idx++;
      advance(e);
      cyc++;
    end
    total++;
    if (idx != 6 || seen.size() != 6) begin
      bad++; $display("FAIL bp_count got=%0d exp=6", seen.size());
    end
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      total++;
      if (seen[i] !== beats[i]) begin
        bad++; $display("FAIL bp_order beat=%0d got=%h exp=%h", i, seen[i], beats[i]);
      end
    end
    total++;
    if (err_len !== 1'b0) begin
      bad++; $display("FAIL bp_err got=%b exp=0", err_len);
    end
    idle_inputs();
  endtask

  task automatic test_idle_words();
    exp_t e;
    int writes;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      s0v = 1; s0d = mk(3'd0, $urandom_range(0, 1), 1, 12'($urandom_range(0, 3)));
      #2 e = model_eval();
      if (fifo_we !== 1'b0 || locked !== 1'b0) writes++;
      advance(e);
    end
    total++;
    if (writes != 0) begin
      bad++; $display("FAIL idle_words got=%0d exp=0", writes);
    end
    s0d = mk(3'd1, 1, 0, 12'd1);
    s1v = 1; s1d = mk(3'd1, 1, 0, 12'd1);
    #2 e = model_eval();
    total++;
    if (fifo_we !== 1'b1 || fifo_din !== (m_rr == 1 ? s1d : s0d)) begin
      bad++; $display("FAIL idle_rr got=%h exp=%h", fifo_din, (m_rr == 1 ? s1d : s0d));
    end
    advance(e);
    idle_inputs();
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      s0v  = ($urandom_range(0, 3) != 0);
      s1v  = ($urandom_range(0, 3) != 0);
      s0d  = mk(3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom_range(0, 1), 12'($urandom_range(0, 4)));
      s1d  = mk(3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom_range(0, 1), 12'($urandom_range(0, 4)));
      full = ($urandom_range(0, 4) == 0);
      clr  = ($urandom_range(0, 19) == 0);
      #2 e = model_eval();
      total++;
      if ({fifo_we, s0r, s1r, grant, locked, err_len} !== {e.we, e.r0, e.r1, e.gnt, e.lck, e.err}) begin
        bad++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", i, {fifo_we, s0r, s1r, grant, locked, err_len}, {e.we, e.r0, e.r1, e.gnt, e.lck, e.err});
      end
      if (e.we) begin
        total++;
        if (fifo_din !== e.din) begin
          bad++; $display("FAIL rand_din cyc=%0d got=%h exp=%h", i, fifo_din, e.din);
        end
      end
      advance(e);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_burst_lock();
    test_len_error();
    test_backpressure();
    test_idle_words();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wsi_req_arbiter.md
Name: wsi_req_arbiter

Overview:
- Shares the single 61-bit WSI request FIFO write port (`generic_fifo_sc_c` instance) between two request sources, `src0` and `src1`.
- Burst-aware round-robin: once a source starts a burst it keeps the grant until its last beat is written.
- Optionally checks precise-burst beat counts against the MBurstLength field.
- Sits between the WSI slave request capture logic and the FIFO's `we`/`din`.

Parameters:
- PRIO_INIT, 0, source favoured by the round-robin pointer out of reset (0 or 1).
- DW, 61, request word width. Fixed by the field map below; not to be overridden.

Ports:
- wciS0_Clk  in  1  clock; everything on posedge.
- wciS0_Rst  in  1  reset, asynchronous, active-high.
- src0_valid  in  1  source 0 presents a request word.
- src0_data  in  61  source 0 word: [60:58] MCmd, [57] MReqLast, [56] MBurstPrecise, [55:44] MBurstLength, [43:12] MData, [11:8] MByteEn, [7:0] MReqInfo.
- src0_ready  out  1  source 0 word accepted this cycle when valid & ready.
- src1_valid, src1_data, src1_ready  as for source 0.
- fifo_full  in  1  FIFO registered full flag (`full_r`), active-high.
- fifo_we  out  1  write strobe to the FIFO.
- fifo_din  out  61  word to the FIFO.
- grant  out  2  one-hot owner of the current or locked burst; 2'b00 when idle.
- locked  out  1  a burst is in progress (state LOCK0/LOCK1).
- err_len  out  1  sticky precise-burst length error.
- err_clr  in  1  synchronous clear of err_len.

Behaviour:
- Reset values: state IDLE, rr_ptr = PRIO_INIT, grant 0, locked 0, err_len 0, beat_cnt 0, len_q 0.
- Outputs during reset: fifo_we 0, both readies 0.
- Valid beat: srcN_valid=1 and MCmd != 3'b000. An idle-command word is never accepted and never drives `fifo_we`.
- Acceptance: accept = valid beat & srcN_ready.
- srcN_ready is combinational: selected source, !fifo_full, not in reset.
- fifo_we = accept. fifo_din = the selected source's data, passed through unmodified. Zero-cycle latency.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE selection:
  - If only one source has a valid beat, select it.
  - If both have valid beats, select rr_ptr.
  - grant shows the selected source even when fifo_full blocks it.
- IDLE transitions on accept:
  - Beat with MReqLast=1: stay IDLE, rr_ptr <= other source.
  - Beat with MReqLast=0: go to LOCKn for the accepted source n. Latch len_q = MBurstLength and prec_q = MBurstPrecise; beat_cnt <= 1.
- LOCKn:
  - Only source n may be selected; the other source's ready is held 0.
  - Each accept increments beat_cnt (12-bit, saturates at 4095).
  - Accepted beat with MReqLast=1: go to IDLE, rr_ptr <= other source.
- Stalls:
  - fifo_full=1 means no accept; state, pointer and counters are held.
  - Source n deasserting valid mid-burst leaves the lock held indefinitely. There is no timeout.
- Single-beat burst (MReqLast=1 on the first beat) never enters LOCK.
- Burst-check logic (feature enabled):
  - Applies when the burst's last beat is accepted and prec_q=1 (a single-beat burst uses the beat's own fields).
  - Error if the total beat count != len_q, or if len_q==0.
  - On error, err_len <= 1, and it stays set until err_clr or reset.
  - err_clr and a new error in the same cycle: the set wins.
  - Imprecise bursts are never checked.
- Asynchronous reset mid-burst aborts to IDLE. A partially written burst stays in the FIFO; its cleanup is the FIFO clr owner's job.

Optional Feature:
- Macro: WSI_ARB_BURST_CHECK_EN.
- Defined: len_q, prec_q, the beat_cnt comparison and err_len setting are implemented as described.
- Undefined:
  - err_len is tied 0; err_clr is ignored.
  - len_q, prec_q and the comparator are not instantiated.
  - beat_cnt is still kept; it is an internal debug signal only.
- Arbitration and lock behaviour are identical in both builds.

Decomposition:
- Shared package `wsi_req_pkg`:
  - field-slice constants (CMD_HI=60, CMD_LO=58, LAST_BIT=57, PREC_BIT=56, LEN_HI=55, LEN_LO=44);
  - WSI_REQ_W=61;
  - CMD_IDLE=3'b000;
  - FSM state encoding (IDLE/LOCK0/LOCK1).
- Sub-module `wsi_burst_checker`: holds beat_cnt, len_q, prec_q and err_len. It is compiled under the macro and fed accept, first-beat and last-beat strobes.

Test Plan:
1. Reset: assert wciS0_Rst mid-LOCK1 with src1_valid=1 -> same cycle, src1_ready=0 and fifo_we=0. After release: grant=0, locked=0, and PRIO_INIT=0 gives src0 priority on the next contention.
2. Contention: both sources send single-beat words (MCmd=3'b001, last=1) every cycle -> fifo_we every cycle, FIFO writes alternate src0,src1,src0,src1.
3. Burst lock:
   - Stimulus: src0 sends a 4-beat precise burst (len=4) while src1 is continuously valid.
   - Required: src1_ready=0 for all 4 beats, locked=1 for beats 2-4, src1 gets the first grant after src0's last beat, err_len stays 0.
4. Length error: src1 sends a precise burst with len=3 but MReqLast on beat 2 -> err_len=1 the cycle after the last beat. Pulse err_clr -> err_len=0.
5. Backpressure: fifo_full=1 for 5 cycles mid-burst -> fifo_we=0, beat_cnt and grant unchanged. Resume -> remaining beats written in order, no duplicates.
6. Idle words: src0_valid=1 with MCmd=0 and src1 idle -> fifo_we never asserted, state stays IDLE, rr_ptr unchanged.
